// File: rtl/vga_sync_gen.sv
// VGA timing generator for the TinyVGA PMOD: counters, registered syncs and packed pixel byte.
// Optional completed-frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [5:0] rgb_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_active,
    output logic       line_start,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] pmod_out,
    output logic [7:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Bounds are 11 bits wide so a 1024-count timing still compares correctly.
    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [7:0] PMOD_IDLE = {~HSYNC_POL, 3'b000, ~VSYNC_POL, 3'b000};

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap;
    logic       hs_act;
    logic       vs_act;
    logic       hs_lvl;
    logic       vs_lvl;
    logic [5:0] rgb_m;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign pix_x        = h_cnt;
    assign pix_y        = v_cnt;
    assign video_active = ({1'b0, h_cnt} < H_VIS) && ({1'b0, v_cnt} < V_VIS);
    assign line_start   = (h_cnt == 10'd0);
    assign frame_start  = (h_cnt == 10'd0) && (v_cnt == 10'd0);

    assign hs_act = ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
    assign vs_act = ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);
    assign hs_lvl = hs_act ? HSYNC_POL : ~HSYNC_POL;
    assign vs_lvl = vs_act ? VSYNC_POL : ~VSYNC_POL;
    assign rgb_m  = video_active ? rgb_in : 6'd0;

    // Syncs live inside the PMOD byte register so they can never drift from the pixel bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            pmod_out <= PMOD_IDLE;
        end else if (en) begin
            pmod_out <= {hs_lvl, rgb_m[0], rgb_m[2], rgb_m[4],
                         vs_lvl, rgb_m[1], rgb_m[3], rgb_m[5]};
        end
    end

    assign hsync = pmod_out[7];
    assign vsync = pmod_out[3];

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
        end else if (en && h_wrap && v_wrap) begin
            frame_q <= frame_q + 8'd1;
        end
    end

    assign frame_cnt = frame_q;
`else
    assign frame_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed-vector bench for vga_sync_gen using a shrunk 16x12 timing so frames stay short.
module tb_vga_sync_gen;

    // Timing: hsync low for h 10..13, vsync low for v 8..9, active 8x6, frame = 192 cycles.
    localparam int HA = 8, HF = 2, HS = 4, HB = 2;
    localparam int VA = 6, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
`ifdef VGA_FRAME_CNT_EN
    localparam logic [7:0] FC_ONE = 8'd1;
`else
    localparam logic [7:0] FC_ONE = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [5:0] rgb_in;
    logic [9:0] pix_x, pix_y;
    logic       video_active, line_start, frame_start, hsync, vsync;
    logic [7:0] pmod_out, frame_cnt;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .rgb_in(rgb_in),
        .pix_x(pix_x), .pix_y(pix_y), .video_active(video_active),
        .line_start(line_start), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .pmod_out(pmod_out), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         adv;
        logic [5:0] rgb;
        logic [9:0] x;
        logic [9:0] y;
        logic       va, ls, fs, hs, vs;
        logic [7:0] pmod;
    } vec_t;

    vec_t tbl[19];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input vec_t e);
        n_vec++;
        if ({pix_x, pix_y, video_active, line_start, frame_start, hsync, vsync, pmod_out} !==
            {e.x, e.y, e.va, e.ls, e.fs, e.hs, e.vs, e.pmod}) begin
            n_bad++;
            $display("FAIL %s: got x=%0d y=%0d va=%b ls=%b fs=%b hs=%b vs=%b pmod=%h, want x=%0d y=%0d va=%b ls=%b fs=%b hs=%b vs=%b pmod=%h",
                     nm, pix_x, pix_y, video_active, line_start, frame_start, hsync, vsync, pmod_out,
                     e.x, e.y, e.va, e.ls, e.fs, e.hs, e.vs, e.pmod);
        end
    endtask

    task automatic chk_val(input string nm, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    initial begin
        int fs_n, hs_n, vs_n;

        // adv, rgb, x, y, va, ls, fs, hs, vs, pmod (pmod reflects the previous position)
        tbl[0]  = '{0,   6'h3F, 10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h88};
        tbl[1]  = '{1,   6'h3F, 10'd1,  10'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF};
        tbl[2]  = '{8,   6'h3F, 10'd9,  10'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h88};
        tbl[3]  = '{2,   6'h3F, 10'd11, 10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08};
        tbl[4]  = '{3,   6'h3F, 10'd14, 10'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08};
        tbl[5]  = '{1,   6'h3F, 10'd15, 10'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h88};
        tbl[6]  = '{1,   6'h3F, 10'd0,  10'd1,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h88};
        tbl[7]  = '{1,   6'h3F, 10'd1,  10'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF};
        tbl[8]  = '{1,   6'h15, 10'd2,  10'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF8};
        tbl[9]  = '{1,   6'h2A, 10'd3,  10'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h8F};
        tbl[10] = '{1,   6'h20, 10'd4,  10'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h89};
        tbl[11] = '{1,   6'h01, 10'd5,  10'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC8};
        tbl[12] = '{107, 6'h3F, 10'd0,  10'd8,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h88};
        tbl[13] = '{1,   6'h3F, 10'd1,  10'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80};
        tbl[14] = '{10,  6'h3F, 10'd11, 10'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[15] = '{21,  6'h3F, 10'd0,  10'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80};
        tbl[16] = '{1,   6'h3F, 10'd1,  10'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h88};
        tbl[17] = '{31,  6'h3F, 10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h88};
        tbl[18] = '{1,   6'h3F, 10'd1,  10'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF};

        rst = 1'b1; en = 1'b0; rgb_in = 6'h00;
        repeat (2) tick();
        rst = 1'b0;
        chk_val("reset_frame_cnt", int'(frame_cnt), 0);

        for (int i = 0; i < 19; i++) begin
            rgb_in = tbl[i].rgb;
            en = 1'b1;
            repeat (tbl[i].adv) tick();
            chk($sformatf("vec%0d", i), tbl[i]);
        end

        // en low: everything holds at (1,0)
        en = 1'b0;
        repeat (5) tick();
        chk("en_hold", '{0, 6'h3F, 10'd1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF});

        // alternate en: 10 enabled cycles over 20 clocks
        for (int i = 0; i < 20; i++) begin
            en = (i % 2 == 0);
            tick();
            if (i == 1)
                chk("alt_mid", '{0, 6'h3F, 10'd2, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF});
        end
        chk("alt_end", '{0, 6'h3F, 10'd11, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08});

        // mid-frame reset at (5,3)
        en = 1'b1;
        repeat (42) tick();
        chk("pre_rst", '{0, 6'h3F, 10'd5, 10'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF});
        rst = 1'b1;
        tick();
        chk("rst_mid", '{0, 6'h3F, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h88});
        chk_val("rst_mid_frame_cnt", int'(frame_cnt), 0);
        rst = 1'b0; en = 1'b0;
        tick();
        chk("rst_release_idle", '{0, 6'h3F, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h88});
        en = 1'b1;
        tick();
        chk("rst_restart", '{0, 6'h3F, 10'd1, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF});
        repeat (3) tick();
        rst = 1'b1; en = 1'b0;
        tick();
        chk("rst_over_en", '{0, 6'h3F, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h88});
        rst = 1'b0;

        // one full frame: count pulses, then the frame counter over 257 frames
        en = 1'b1;
        fs_n = 0; hs_n = 0; vs_n = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            fs_n += int'(frame_start);
            hs_n += int'(!hsync);
            vs_n += int'(!vsync);
        end
        chk_val("frame_start_count", fs_n, 1);
        chk_val("hsync_low_cycles", hs_n, HS * VT);
        chk_val("vsync_low_cycles", vs_n, VS * HT);
        chk_val("frame_cnt_1", int'(frame_cnt), int'(FC_ONE));
        repeat (255 * FRAME) tick();
        chk_val("frame_cnt_256", int'(frame_cnt), 0);
        tick();
        chk_val("frame_cnt_hold_pos", int'(pix_x), 1);
        repeat (FRAME - 1) tick();
        chk_val("frame_cnt_257", int'(frame_cnt), int'(FC_ONE));
        chk("frame_257_pos", '{0, 6'h3F, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h88});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
